// File: rtl/wishbone_bus_if.sv
// Single-outstanding Wishbone master bridge between the CPU mem stage and a Wishbone slave.
// The request is registered; load data is forwarded combinationally in the ack cycle.
module wishbone_bus_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    StIdle         = 2'd0,
    StBusy         = 2'd1,
    StWaitForStall = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [3:0]  sel;
    logic        cyc;
  } wb_req_t;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state;
  wb_req_t     req;
  logic [31:0] rd_buf;
  logic [15:0] tmo_cnt;

  logic accept;
  logic timeout;
  logic stalled;

  assign accept  = (state == StIdle) && cpu_ce_i && !flush_i;
  assign timeout = (tmo_cnt == TimeoutLast);
  assign stalled = |stall_i;

  // One register drives both cyc and stb so they can never diverge.
  assign wb_addr_o = req.addr;
  assign wb_data_o = req.data;
  assign wb_we_o   = req.we;
  assign wb_sel_o  = req.sel;
  assign wb_cyc_o  = req.cyc;
  assign wb_stb_o  = req.cyc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      req       <= '0;
      rd_buf    <= '0;
      tmo_cnt   <= '0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        StIdle: begin
          if (accept) begin
            req.addr <= cpu_addr_i;
            req.data <= cpu_data_i;
            req.we   <= cpu_we_i;
            req.sel  <= cpu_sel_i;
            req.cyc  <= 1'b1;
            tmo_cnt  <= '0;
            state    <= StBusy;
          end else begin
            req <= '0;
          end
        end
        StBusy: begin
          if (flush_i) begin
            // A same-cycle ack is dropped: the flushed instruction must not see its data.
            req    <= '0;
            rd_buf <= '0;
            state  <= StIdle;
          end else if (wb_ack_i) begin
            req <= '0;
            if (!req.we) begin
              rd_buf <= wb_data_i;
            end
            state <= stalled ? StWaitForStall : StIdle;
          end else if (timeout) begin
            req       <= '0;
            rd_buf    <= '0;
            bus_err_o <= 1'b1;
            state     <= stalled ? StWaitForStall : StIdle;
          end else begin
            tmo_cnt <= (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
          end
        end
        StWaitForStall: begin
          if (flush_i) begin
            rd_buf <= '0;
            state  <= StIdle;
          end else if (!stalled) begin
            state <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
          req   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    case (state)
      StIdle: stallreq_o = cpu_ce_i && !flush_i;
      StBusy: begin
        stallreq_o = !(wb_ack_i || flush_i);
        if (wb_ack_i && !flush_i && !req.we) begin
          cpu_data_o = wb_data_i;
        end
      end
      StWaitForStall: cpu_data_o = rd_buf;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Bench for wishbone_bus_if: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model of the bridge.
module tb_wishbone_bus_if;

  localparam int unsigned Tmo = 4;

  logic        clk;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        bus_err_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;

  int checks = 0;
  int failures = 0;

  wishbone_bus_if #(
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .cpu_ce_i  (cpu_ce_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i),
    .cpu_we_i  (cpu_we_i),
    .cpu_sel_i (cpu_sel_i),
    .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o),
    .bus_err_o (bus_err_o),
    .wb_addr_o (wb_addr_o),
    .wb_data_o (wb_data_o),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o),
    .wb_stb_o  (wb_stb_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_data_i (wb_data_i),
    .wb_ack_i  (wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: an outstanding request, how long it has waited, whether the
  // bridge is parked behind a pipeline stall, the last delivered load word, and the error flag.
  bit          m_valid = 0;
  bit          m_pend = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  bit          m_we = 0;
  logic [3:0]  m_sel = '0;
  int          m_waited = 0;
  bit          m_hold = 0;
  logic [31:0] m_buf = '0;
  bit          m_err = 0;

  initial begin
    logic        exp_stall;
    logic [31:0] exp_data;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        if (m_hold)      exp_stall = 1'b0;
        else if (m_pend) exp_stall = !(wb_ack_i || flush_i);
        else             exp_stall = cpu_ce_i && !flush_i;
        if (m_hold)                                    exp_data = m_buf;
        else if (m_pend && wb_ack_i && !flush_i && !m_we) exp_data = wb_data_i;
        else                                           exp_data = '0;
        check("m_cyc", 32'(wb_cyc_o), 32'(m_pend));
        check("m_stb", 32'(wb_stb_o), 32'(m_pend));
        check("m_addr", wb_addr_o, m_pend ? m_addr : 32'd0);
        check("m_wdata", wb_data_o, m_pend ? m_wdata : 32'd0);
        check("m_we", 32'(wb_we_o), 32'(m_pend && m_we));
        check("m_sel", 32'(wb_sel_o), m_pend ? 32'(m_sel) : 32'd0);
        check("m_stallreq", 32'(stallreq_o), 32'(exp_stall));
        check("m_err", 32'(bus_err_o), 32'(m_err));
        // Data for a flushed request is don't-care in its ack cycle.
        if (!(m_pend && wb_ack_i && flush_i)) check("m_rdata", cpu_data_o, exp_data);
      end
      if (rst) begin
        m_valid = 1;
        m_pend = 0;
        m_hold = 0;
        m_buf = '0;
        m_err = 0;
      end else begin
        m_err = 0;
        if (m_hold) begin
          if (flush_i) begin
            m_hold = 0;
            m_buf = '0;
          end else if (stall_i == 6'd0) begin
            m_hold = 0;
          end
        end else if (m_pend) begin
          if (flush_i) begin
            m_pend = 0;
            m_buf = '0;
          end else if (wb_ack_i) begin
            m_pend = 0;
            if (!m_we) m_buf = wb_data_i;
            m_hold = (stall_i != 6'd0);
          end else if (m_waited + 1 == int'(Tmo)) begin
            m_pend = 0;
            m_buf = '0;
            m_err = 1;
            m_hold = (stall_i != 6'd0);
          end else begin
            m_waited++;
          end
        end else if (cpu_ce_i && !flush_i) begin
          m_pend = 1;
          m_addr = cpu_addr_i;
          m_wdata = cpu_data_i;
          m_we = cpu_we_i;
          m_sel = cpu_sel_i;
          m_waited = 0;
        end
      end
    end
  end

  // Write acked with the pipeline stalled one cycle; the parked cycle shows the read buffer.
  task automatic write_stall(input logic [31:0] a, input logic [31:0] d, input string tag);
    cpu_ce_i = 1'b1;
    cpu_we_i = 1'b1;
    cpu_addr_i = a;
    cpu_data_i = d;
    cpu_sel_i = 4'b0011;
    step();
    cpu_ce_i = 1'b0;
    wb_ack_i = 1'b1;
    stall_i = 6'b000001;
    @(negedge clk);
    check({tag, "_addr"}, wb_addr_o, a);
    check({tag, "_data"}, wb_data_o, d);
    check({tag, "_we"}, 32'(wb_we_o), 32'd1);
    check({tag, "_sel"}, 32'(wb_sel_o), 32'd3);
    step();
    wb_ack_i = 1'b0;
    stall_i = 6'd0;
    @(negedge clk);
    check({tag, "_buf_zero"}, cpu_data_o, 32'd0);
    check({tag, "_wait_stallreq"}, 32'(stallreq_o), 32'd0);
    step();
    @(negedge clk);
    check({tag, "_idle_cyc"}, 32'(wb_cyc_o), 32'd0);
    step();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    stall_i = '0;
    flush_i = 1'b0;
    cpu_ce_i = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    cpu_we_i = 1'b0;
    cpu_sel_i = '0;
    wb_data_i = '0;
    wb_ack_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_addr", wb_addr_o, 32'd0);
    check("rst_stallreq", 32'(stallreq_o), 32'd0);
    check("rst_rdata", cpu_data_o, 32'd0);
    check("rst_err", 32'(bus_err_o), 32'd0);
    step();

    write_stall(32'h0000_2000, 32'h1234_5678, "wr");

    // Read, ack on the second BUSY cycle
    cpu_ce_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h0000_1000;
    cpu_sel_i = 4'hF;
    @(negedge clk);
    check("rd_req_stallreq", 32'(stallreq_o), 32'd1);
    step();
    cpu_ce_i = 1'b0;
    @(negedge clk);
    check("rd_b0_stb", 32'(wb_stb_o), 32'd1);
    check("rd_b0_addr", wb_addr_o, 32'h0000_1000);
    check("rd_b0_stallreq", 32'(stallreq_o), 32'd1);
    step();
    wb_ack_i = 1'b1;
    wb_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rd_ack_data", cpu_data_o, 32'hDEAD_BEEF);
    check("rd_ack_stallreq", 32'(stallreq_o), 32'd0);
    check("rd_ack_stb", 32'(wb_stb_o), 32'd1);
    step();
    wb_ack_i = 1'b0;
    @(negedge clk);
    check("rd_idle_cyc", 32'(wb_cyc_o), 32'd0);
    check("rd_idle_data", cpu_data_o, 32'd0);
    step();

    // Read acked under a stall held for three parked cycles
    cpu_ce_i = 1'b1;
    cpu_addr_i = 32'h0000_3000;
    step();
    cpu_ce_i = 1'b0;
    wb_ack_i = 1'b1;
    wb_data_i = 32'hCAFE_F00D;
    stall_i = 6'b001111;
    step();
    wb_ack_i = 1'b0;
    wb_data_i = '0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) stall_i = 6'd0;
      @(negedge clk);
      check("wfs_data", cpu_data_o, 32'hCAFE_F00D);
      check("wfs_stallreq", 32'(stallreq_o), 32'd0);
      step();
    end
    @(negedge clk);
    check("wfs_exit_data", cpu_data_o, 32'd0);
    step();

    // Flush concurrent with ack
    cpu_ce_i = 1'b1;
    cpu_addr_i = 32'h0000_4000;
    step();
    cpu_ce_i = 1'b0;
    flush_i = 1'b1;
    wb_ack_i = 1'b1;
    wb_data_i = 32'hFFFF_FFFF;
    step();
    flush_i = 1'b0;
    wb_ack_i = 1'b0;
    @(negedge clk);
    check("fl_cyc", 32'(wb_cyc_o), 32'd0);
    check("fl_err", 32'(bus_err_o), 32'd0);
    step();
    @(negedge clk);
    check("fl_err_late", 32'(bus_err_o), 32'd0);
    step();
    write_stall(32'h0000_4004, 32'hA5A5_5A5A, "flbuf");

    // Timeout with no ack
    cpu_ce_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h0000_5000;
    step();
    cpu_ce_i = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!wb_stb_o) break;
      n++;
      step();
    end
    check("to_stb_cycles", 32'(n), 32'd4);
    check("to_err_pulse", 32'(bus_err_o), 32'd1);
    check("to_rdata", cpu_data_o, 32'd0);
    step();
    @(negedge clk);
    check("to_err_single", 32'(bus_err_o), 32'd0);
    step();

    // Reset mid-BUSY, then a normal read
    cpu_ce_i = 1'b1;
    cpu_addr_i = 32'h0000_6000;
    step();
    cpu_ce_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_cyc", 32'(wb_cyc_o), 32'd0);
    check("mrst_addr", wb_addr_o, 32'd0);
    check("mrst_stallreq", 32'(stallreq_o), 32'd0);
    check("mrst_rdata", cpu_data_o, 32'd0);
    step();
    cpu_ce_i = 1'b1;
    cpu_addr_i = 32'h0000_7000;
    step();
    cpu_ce_i = 1'b0;
    wb_ack_i = 1'b1;
    wb_data_i = 32'h600D_F00D;
    @(negedge clk);
    check("mrst_rd_data", cpu_data_o, 32'h600D_F00D);
    step();
    wb_ack_i = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(199) == 0);
      flush_i = ($urandom_range(14) == 0);
      cpu_ce_i = 1'($urandom_range(1));
      cpu_addr_i = $urandom;
      cpu_data_i = $urandom;
      cpu_we_i = 1'($urandom_range(1));
      cpu_sel_i = 4'($urandom);
      wb_ack_i = ($urandom_range(9) < 3);
      wb_data_i = $urandom;
      stall_i = ($urandom_range(1) == 0) ? 6'd0 : 6'($urandom);
      step();
    end
    rst = 1'b0;
    flush_i = 1'b0;
    cpu_ce_i = 1'b0;
    wb_ack_i = 1'b0;
    stall_i = '0;
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wishbone_bus_if.md
WISHBONE_BUS_IF -- requirements
Module: wishbone_bus_if

Interface
REQ-001 SHALL take parameter TIMEOUT_CYCLES, default 255, meaning the maximum cycles in BUSY awaiting wb_ack_i before abort (range 1..65535).
REQ-002 SHALL have port clk  input  1  the single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port stall_i  input  6  pipeline stall vector from ctrl.
REQ-005 SHALL have port flush_i  input  1  pipeline flush from ctrl (exception).
REQ-006 SHALL have port cpu_ce_i  input  1  CPU data-memory access request.
REQ-007 SHALL have port cpu_addr_i  input  32  access byte address.
REQ-008 SHALL have port cpu_data_i  input  32  store data.
REQ-009 SHALL have port cpu_we_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port cpu_sel_i  input  4  byte lane select.
REQ-011 SHALL have port cpu_data_o  output  32  load data to the mem stage.
REQ-012 SHALL have port stallreq_o  output  1  stall request to ctrl.
REQ-013 SHALL have port bus_err_o  output  1  one-cycle timeout error pulse.
REQ-014 SHALL have ports wb_addr_o (32), wb_data_o (32), wb_we_o (1), wb_sel_o (4), wb_stb_o (1), wb_cyc_o (1), all outputs and registered: the Wishbone master request.
REQ-015 SHALL have ports wb_data_i  input  32 and wb_ack_i  input  1: the Wishbone slave response.

Function
REQ-016 SHALL implement states IDLE, BUSY, WAIT_FOR_STALL, encoded in 2 bits.
REQ-017 IDLE, cpu_ce_i=1 and flush_i=0: SHALL register cyc=stb=1, addr/data/we/sel from cpu inputs, clear the timeout counter, and enter BUSY next cycle.
REQ-018 IDLE otherwise: SHALL hold all wb_* outputs at 0.
REQ-019 BUSY priority SHALL be flush_i > wb_ack_i > timeout.
REQ-020 BUSY, flush_i=1: SHALL zero all wb_* outputs and the read buffer and go to IDLE; any ack that same cycle is discarded.
REQ-021 BUSY, wb_ack_i=1: SHALL zero all wb_* outputs, latch wb_data_i into the read buffer when wb_we_o=0, and go to WAIT_FOR_STALL if stall_i!=0, else IDLE.
REQ-022 BUSY, no ack: counter SHALL increment (16-bit, saturating); when it reaches TIMEOUT_CYCLES-1, the bridge SHALL zero wb_* and the read buffer, pulse bus_err_o for exactly one cycle, and follow the REQ-021 next-state rule.
REQ-023 WAIT_FOR_STALL: SHALL stay until stall_i==6'b000000, then go to IDLE; flush_i=1 SHALL force IDLE and clear the read buffer.
REQ-024 stallreq_o (combinational) SHALL be 1 in IDLE when cpu_ce_i=1 and flush_i=0, 1 in BUSY unless wb_ack_i=1 or flush_i=1, and 0 in WAIT_FOR_STALL.
REQ-025 cpu_data_o (combinational) SHALL equal wb_data_i in BUSY on an ack cycle for reads, the read buffer in WAIT_FOR_STALL, and 0 otherwise.
REQ-026 Best-case latency SHALL be request cycle plus one cycle into BUSY plus the slave ack cycle; load data reaches the mem stage in the ack cycle.
REQ-027 Writes SHALL never modify the read buffer.
REQ-028 Exactly one Wishbone transfer SHALL be issued per CPU request.
REQ-029 cyc and stb SHALL be identical at all times.
REQ-030 Back-to-back requests SHALL re-enter BUSY from IDLE with no extra bubble beyond the IDLE cycle.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, zero all wb_* outputs, the read buffer and the counter, and hold bus_err_o at 0, including mid-BUSY with an outstanding transfer.
REQ-032 After reset, stallreq_o=0 and cpu_data_o=0 SHALL hold until cpu_ce_i is asserted.

Verification
REQ-033 Read: ce=1, we=0, addr=0x0000_1000, slave ack 2 cycles after stb with data 0xDEAD_BEEF -> cyc/stb high for 2 cycles, stallreq_o high until the ack cycle, cpu_data_o=0xDEAD_BEEF on the ack cycle, then IDLE.
REQ-034 Write: ce=1, we=1, sel=4'b0011, data=0x1234_5678 -> wb_* outputs carry exactly these values; the read buffer stays 0.
REQ-035 Ack while stall_i=6'b001111 held 3 cycles -> state WAIT_FOR_STALL, cpu_data_o=buffered data for 3 cycles, stallreq_o=0, then IDLE.
REQ-036 flush_i=1 in BUSY concurrent with wb_ack_i=1 -> cyc=0 next cycle, read buffer 0, IDLE, and no bus_err_o pulse.
REQ-037 TIMEOUT_CYCLES=4 with no ack -> stb high 4 cycles, single bus_err_o pulse, cpu_data_o=0, IDLE.
REQ-038 rst=1 asserted mid-BUSY -> all outputs 0 on the next edge; a following request completes normally.
